// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: sweep FSM encoding,
// default number formats and a width-parameterised saturating adder.
package snn_pkg;

  localparam int DEF_WIDTH      = 18;
  localparam int DEF_DECAY_FRAC = 8;
  localparam int SAT_W          = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CALC  = 2'd2,
    ST_DONE  = 2'd3
  } eng_state_e;

  typedef logic signed [SAT_W-1:0] wide_t;

  // Operands arrive sign-extended; the sum is clamped to a w-bit two's complement range.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    wide_t hi;
    wide_t lo;
    wide_t sum;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = ~hi;
    sum = a + b;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/syn_current_engine_if.sv
// Step request, weight fetch and current stream between the neuron core and
// the synaptic current engine.
interface syn_current_engine_if
  import snn_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int CH_W = $clog2(N_CH);

  logic                    step_valid;
  logic                    step_ready;
  logic [N_CH-1:0]         spike;
  logic                    clear;
  logic                    w_rd;
  logic [CH_W-1:0]         w_addr;
  logic signed [WIDTH-1:0] w_data;
  logic                    i_valid;
  logic [CH_W-1:0]         i_ch;
  logic signed [WIDTH-1:0] i_out;
  logic                    done;

  // master: the neuron core plus weight memory; slave: the engine.
  modport master (
    output step_valid, spike, clear, w_data,
    input  step_ready, w_rd, w_addr, i_valid, i_ch, i_out, done
  );

  modport slave (
    input  step_valid, spike, clear, w_data,
    output step_ready, w_rd, w_addr, i_valid, i_ch, i_out, done
  );

endinterface

// File: rtl/syn_decay_mult.sv
// Combinational current update: fixed-point decay (floor rounding) and,
// on a spike, a saturating weight add on top of either the old or decayed current.
module syn_decay_mult
  import snn_pkg::*;
#(
  parameter int          WIDTH      = DEF_WIDTH,
  parameter int          DECAY_FRAC = DEF_DECAY_FRAC,
  parameter int unsigned DECAY      = 169,
  parameter int          MODE       = 0
) (
  input  logic signed [WIDTH-1:0] cur_i,
  input  logic signed [WIDTH-1:0] w_i,
  input  logic                    spike_i,
  output logic signed [WIDTH-1:0] cur_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] DECAY_S = PW'(DECAY);

  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] dec;
  logic signed [WIDTH-1:0] base;
  wide_t                   sum;

  // DECAY is below one in fixed point, so the shifted product always fits WIDTH.
  always_comb begin
    prod  = PW'(cur_i) * DECAY_S;
    dec   = WIDTH'(prod >>> DECAY_FRAC);
    base  = (MODE != 0) ? dec : cur_i;
    sum   = sat_add(SAT_W'(base), SAT_W'(w_i), WIDTH);
    cur_o = spike_i ? WIDTH'(sum) : dec;
  end

endmodule

// File: rtl/syn_current_engine.sv
// N-channel time-multiplexed synaptic current engine: each accepted step sweeps
// every channel (fetch weight, update current) and streams the new currents out.
module syn_current_engine
  import snn_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter int          WIDTH      = DEF_WIDTH,
  parameter int          DECAY_FRAC = DEF_DECAY_FRAC,
  parameter int unsigned DECAY      = 169,
  parameter int          MODE       = 0
) (
  input logic                clk,
  input logic                reset,
  syn_current_engine_if.slave bus
);

  localparam int CH_W = $clog2(N_CH);

  eng_state_e              state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [N_CH-1:0]         spike_q;
  logic                    i_valid_q;
  logic signed [WIDTH-1:0] i_out_q;
  logic [CH_W-1:0]         i_ch_q;
  logic signed [WIDTH-1:0] cur_all [N_CH];
  logic signed [WIDTH-1:0] cur_new;
  logic                    accept;

  assign accept         = bus.step_valid & bus.step_ready;
  assign bus.step_ready = (state_q == ST_IDLE) && !bus.clear && !reset;
  assign bus.w_rd       = (state_q == ST_FETCH);
  assign bus.w_addr     = ch_q;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.i_valid    = i_valid_q;
  assign bus.i_ch       = i_ch_q;
  assign bus.i_out      = i_out_q;

  syn_decay_mult #(
    .WIDTH      (WIDTH),
    .DECAY_FRAC (DECAY_FRAC),
    .DECAY      (DECAY),
    .MODE       (MODE)
  ) u_decay_mult (
    .cur_i   (cur_all[ch_q]),
    .w_i     (bus.w_data),
    .spike_i (spike_q[ch_q]),
    .cur_o   (cur_new)
  );

  // Per-channel current store; clear is honoured only while idle.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic signed [WIDTH-1:0] chan_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          chan_q <= '0;
        end else if (state_q == ST_IDLE && bus.clear) begin
          chan_q <= '0;
        end else if (state_q == ST_CALC && ch_q == CH_W'(gi)) begin
          chan_q <= cur_new;
        end
      end
      assign cur_all[gi] = chan_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_FETCH;
          ch_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_CALC;
      ST_CALC: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      spike_q   <= '0;
      i_valid_q <= 1'b0;
      i_out_q   <= '0;
      i_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      i_valid_q <= (state_q == ST_CALC);
      if (accept) begin
        spike_q <= bus.spike;
      end
      // Output register trails CALC by one cycle, so i_valid lands in FETCH/DONE.
      if (state_q == ST_CALC) begin
        i_out_q <= cur_new;
        i_ch_q  <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_syn_current_engine.sv
// Bench for syn_current_engine: MODE=0 and MODE=1 instances share stimulus and are
// checked every cycle against an integer model of the sweep, plus literal expectations.
`timescale 1ns/1ps
module tb_syn_current_engine;

  localparam int N_CH = 4;
  localparam int WIDTH = 18;
  localparam int SMAX = 131071;
  localparam int SMIN = -131072;
  localparam int SWEEP = 2 * N_CH + 1;
  localparam int SENT = 32'h7fff_fff0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  syn_current_engine_if #(.N_CH(N_CH), .WIDTH(WIDTH)) if0 ();
  syn_current_engine_if #(.N_CH(N_CH), .WIDTH(WIDTH)) if1 ();

  syn_current_engine #(.N_CH(N_CH), .WIDTH(WIDTH), .DECAY_FRAC(8), .DECAY(169), .MODE(0))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  syn_current_engine #(.N_CH(N_CH), .WIDTH(WIDTH), .DECAY_FRAC(8), .DECAY(169), .MODE(1))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wt[N_CH];
  int mcur[2][N_CH];
  int exp_v[2][N_CH];
  int last[2][N_CH];
  int acc_cyc = 0;
  int acc_cnt = 0;
  int done_d = -1;
  bit live = 1'b0;
  bit post_reset = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference arithmetic: floor of cur*169/256, clamp to 18-bit signed range.
  function automatic int m_decay(input int a);
    longint p;
    longint q;
    p = longint'(a) * 169;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int m_sat(input int s);
    if (s > SMAX) return SMAX;
    if (s < SMIN) return SMIN;
    return s;
  endfunction

  function automatic int m_next(input int mode, input int c, input bit sp, input int w);
    if (!sp) return m_decay(c);
    return m_sat(((mode == 1) ? m_decay(c) : c) + w);
  endfunction

  // Weight memory: data follows the read strobe by one cycle, junk otherwise.
  initial begin
    bit rd0, rd1;
    int a0, a1;
    if0.w_data = '0;
    if1.w_data = '0;
    forever begin
      @(negedge clk);
      rd0 = if0.w_rd; a0 = int'(if0.w_addr);
      rd1 = if1.w_rd; a1 = int'(if1.w_addr);
      @(posedge clk);
      #1;
      if0.w_data = rd0 ? WIDTH'(wt[a0]) : 18'sh15555;
      if1.w_data = rd1 ? WIDTH'(wt[a1]) : 18'sh2aaaa;
    end
  end

  // Per-cycle compare against the model, then apply this cycle's events.
  initial begin
    int d, ech;
    bit busy, exp_iv, exp_done, exp_rd, exp_ready;
    bit rdy[2], iv[2], dn[2], rd[2];
    int addr[2], ich[2], iout[2];
    forever begin
      @(negedge clk);
      rdy[0] = if0.step_ready; iv[0] = if0.i_valid; dn[0] = if0.done; rd[0] = if0.w_rd;
      addr[0] = int'(if0.w_addr); ich[0] = int'(if0.i_ch); iout[0] = int'(if0.i_out);
      rdy[1] = if1.step_ready; iv[1] = if1.i_valid; dn[1] = if1.done; rd[1] = if1.w_rd;
      addr[1] = int'(if1.w_addr); ich[1] = int'(if1.i_ch); iout[1] = int'(if1.i_out);

      d = cyc - acc_cyc;
      busy = live && d <= SWEEP;
      exp_iv = busy && d >= 3 && (d % 2) == 1;
      ech = (d - 3) / 2;
      exp_done = busy && d == SWEEP;
      exp_rd = busy && d >= 1 && d <= 2 * N_CH - 1 && (d % 2) == 1;
      exp_ready = !busy && !if0.clear && !reset;

      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_step_ready", m), int'(rdy[m]), int'(exp_ready));
        chk($sformatf("m%0d_i_valid", m), int'(iv[m]), int'(exp_iv));
        chk($sformatf("m%0d_done", m), int'(dn[m]), int'(exp_done));
        chk($sformatf("m%0d_w_rd", m), int'(rd[m]), int'(exp_rd));
        if (exp_rd) chk($sformatf("m%0d_w_addr", m), addr[m], (d - 1) / 2);
        if (exp_iv && iv[m]) begin
          chk($sformatf("m%0d_i_ch", m), ich[m], ech);
          chk($sformatf("m%0d_i_out_ch%0d", m, ech), iout[m], exp_v[m][ech]);
          last[m][ech] = iout[m];
        end
        if (post_reset) begin
          chk($sformatf("m%0d_rst_i_out", m), iout[m], 0);
          chk($sformatf("m%0d_rst_i_ch", m), ich[m], 0);
          chk($sformatf("m%0d_rst_w_addr", m), addr[m], 0);
        end
      end
      if (dn[0] && live) done_d = d;

      post_reset = 1'b0;
      if (reset) begin
        live = 1'b0;
        post_reset = 1'b1;
        for (int m = 0; m < 2; m++)
          for (int c = 0; c < N_CH; c++) mcur[m][c] = 0;
      end else if (!busy && if0.clear) begin
        for (int m = 0; m < 2; m++)
          for (int c = 0; c < N_CH; c++) mcur[m][c] = 0;
      end else if (!busy && if0.step_valid) begin
        acc_cyc = cyc;
        live = 1'b1;
        acc_cnt++;
        for (int m = 0; m < 2; m++)
          for (int c = 0; c < N_CH; c++) begin
            exp_v[m][c] = m_next(m, mcur[m][c], if0.spike[c], wt[c]);
            mcur[m][c] = exp_v[m][c];
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [N_CH-1:0] sp, input bit clr);
    if0.step_valid = v; if1.step_valid = v;
    if0.spike = sp;     if1.spike = sp;
    if0.clear = clr;    if1.clear = clr;
  endtask

  task automatic do_clear();
    set_in(1'b0, '0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0);
  endtask

  // One sweep; hold keeps step_valid high throughout, abort_at asserts reset at that offset.
  task automatic do_sweep(input logic [N_CH-1:0] sp, input int w0, input int w1,
                          input int w2, input int w3, input bit hold, input int abort_at);
    int n = 0;
    wt = '{w0, w1, w2, w3};
    done_d = -1;
    for (int c = 0; c < N_CH; c++) begin
      last[0][c] = SENT;
      last[1][c] = SENT;
    end
    while (!if0.step_ready && n < 40) begin
      tick();
      n++;
    end
    if (!if0.step_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: step_ready stayed %0d, required 1", if0.step_ready);
      return;
    end
    $display("step: spike=%b w=%0d,%0d,%0d,%0d hold=%0d abort_at=%0d",
             sp, w0, w1, w2, w3, hold, abort_at);
    set_in(1'b1, sp, 1'b0);
    tick();
    if (!hold) set_in(1'b0, '0, 1'b0);
    for (int k = 1; k <= SWEEP; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(1'b0, '0, 1'b0);
        tick();
        return;
      end
      tick();
    end
    set_in(1'b0, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_before;
    set_in(1'b0, '0, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: zero currents after reset, done at 9 cycles
    do_sweep(4'b0000, 11, 22, 33, 44, 1'b0, 0);
    for (int c = 0; c < N_CH; c++) chk($sformatf("t1_ch%0d", c), last[0][c], 0);
    chk("t1_done_latency", done_d, 9);

    // 2: spike add then two decays
    do_clear();
    do_sweep(4'b0010, 0, 1000, 0, 0, 1'b0, 0);
    chk("t2_add", last[0][1], 1000);
    do_sweep(4'b0000, 0, 0, 0, 0, 1'b0, 0);
    chk("t2_decay1", last[0][1], 660);
    do_sweep(4'b0000, 0, 0, 0, 0, 1'b0, 0);
    chk("t2_decay2", last[0][1], 435);

    // 3: saturation both ways, negative decay on ch3, ch1 weight ignored
    do_clear();
    do_sweep(4'b1101, 131000, 0, -130500, -1000, 1'b0, 0);
    do_sweep(4'b0101, 2000, 5555, -2000, 7777, 1'b0, 0);
    chk("t3_sat_pos", last[0][0], 131071);
    chk("t3_sat_neg", last[0][2], -131072);
    chk("t3_nospike_ch1", last[0][1], 0);
    chk("t4_neg_decay_m0", last[0][3], -661);
    chk("t4_neg_decay_m1", last[1][3], -661);

    // 4: decay-then-add vs plain add
    do_clear();
    do_sweep(4'b0010, 0, 1000, 0, 0, 1'b0, 0);
    do_sweep(4'b0010, 0, 100, 0, 0, 1'b0, 0);
    chk("t4_mode1", last[1][1], 760);
    chk("t4_mode0", last[0][1], 1100);

    // 5: reset during ch2 CALC, then everything reads zero
    do_sweep(4'b1111, 10, 20, 30, 40, 1'b0, 6);
    chk("t5_ch2_suppressed", last[0][2], SENT);
    do_sweep(4'b0000, 5, 5, 5, 5, 1'b0, 0);
    for (int c = 0; c < N_CH; c++) chk($sformatf("t5_zero_ch%0d", c), last[1][c], 0);

    // 6: clear beats step_valid; step_valid held through a sweep is not re-accepted
    do_sweep(4'b0001, 500, 0, 0, 0, 1'b0, 0);
    chk("t6_load", last[0][0], 500);
    acc_before = acc_cnt;
    set_in(1'b1, 4'b1111, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0);
    chk("t6_clear_not_accepted", acc_cnt - acc_before, 0);
    do_sweep(4'b0000, 9, 9, 9, 9, 1'b1, 0);
    chk("t6_single_accept", acc_cnt - acc_before, 1);
    for (int c = 0; c < N_CH; c++) chk($sformatf("t6_zero_ch%0d", c), last[0][c], 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
